vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
- Raster timing generator and colour output stage for 640x480@60 Hz VGA on a 25 MHz pixel clock.
- Upstream side: counts pixels and lines, and drives the downscaled pixel address (160x120 or 320x240) to the game pixel generator.
- Downstream side: registers the generator's 10-bit RGB, delays sync/blank to match the generator's pipeline latency, forces black outside the visible area, and drives the DAC pins.

Parameters:
- RESOLUTION, "160x120", logical resolution; "320x240" also legal. Sets shift: 2 for 160x120, 1 for 320x240.
- H_VIS / H_FP / H_SYNC / H_BP, 640/16/96/48, horizontal timing in pixel clocks.
- V_VIS / V_FP / V_SYNC / V_BP, 480/10/2/33, vertical timing in lines.
- PIPE_DELAY, 2, clocks from addr_x/addr_y change to valid colour at vga_r1/g1/b1 inputs (legal range 1..4).

Ports:
- vga_clk  in  1  pixel clock, 25 MHz.
- resetn  in  1  asynchronous active-low reset.
- addr_x  out  8 (160x120) / 9 (320x240)  logical column.
- addr_y  out  7 (160x120) / 8 (320x240)  logical row.
- frame_start  out  1  one-clock pulse at hcount=0, vcount=0.
- vga_r1 / vga_g1 / vga_b1  in  10 each  colour from the pixel generator, PIPE_DELAY behind addr.
- VGA_R / VGA_G / VGA_B  out  10 each  DAC colour.
- VGA_HS / VGA_VS  out  1  active-low syncs.
- VGA_BLANK_N  out  1  low outside the visible area.
- VGA_SYNC_N  out  1  tied 0.
- VGA_CLK  out  1  equal to vga_clk.

Behaviour:
- Counters:
  - hcount 10 bit, 0..799, wraps to 0.
  - vcount 10 bit, 0..524; increments when hcount wraps 799->0, wraps 524->0.
  - H_TOTAL = 800, V_TOTAL = 525, both derived from the parameters.
- Visibility: vis = (hcount < H_VIS) && (vcount < V_VIS).
- Address mapping:
  - addr_x = hcount >> shift and addr_y = vcount >> shift, both registered, so each value is held 4 clocks (or 2 clocks at shift 1).
  - addr_x = 0 when hcount >= H_VIS; addr_y = 0 when vcount >= V_VIS. Never out of range.
- Raw sync and blank:
  - hs_raw = 0 for hcount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
  - vs_raw = 0 for vcount in [490, 491].
  - blank_raw = vis.
- Alignment:
  - hs_raw, vs_raw and blank_raw pass through a shift register of depth PIPE_DELAY+1.
  - The extra stage is the RGB capture register, so VGA_HS/VS/BLANK_N and VGA_R/G/B change on the same edge.
- Colour:
  - VGA_R/G/B <= delayed_blank ? vga_r1/g1/b1 : 0.
  - Colour is never non-zero while VGA_BLANK_N = 0.
- frame_start: registered, asserted one clock when hcount=0 and vcount=0. Not delayed.
- Reset (asynchronous, resetn=0):
  - hcount, vcount, addr_x, addr_y, frame_start and all RGB outputs go to 0.
  - VGA_HS and VGA_VS go to 1 (inactive); all delay-line stages are set to 1 for sync and 0 for blank.
  - VGA_BLANK_N goes to 0.
  - After release, the first rising edge advances hcount to 1; the raster restarts at the frame origin.
  - Reset mid-frame truncates that frame with no glitch pulse on HS/VS.
- Totals: exactly 800x525 = 420000 clocks per frame.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*, V_*, totals);
  - the resolution-to-shift function;
  - the address width functions, reused by the game module's addr ports.
- One sub-module, vga_delay_line: a parameterised-depth, parameterised-width shift register with an async-reset value. It is instanced once for {hs, vs, blank}.

Test Plan:
- Reset: hold resetn=0 for 10 clocks -> VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, addr=(0,0). Release -> frame_start seen 420000 clocks later, and every 420000 clocks after that.
- Horizontal timing: measure one line -> period 800; VGA_HS low for exactly 96 clocks, starting 656+PIPE_DELAY+1 clocks after hcount=0; VGA_BLANK_N high for 640 clocks.
- Vertical timing: measure over 2 frames -> VGA_VS low for exactly 2 lines (1600 clocks), at lines 490-491; VGA_BLANK_N low for all of lines 480-524.
- Address mapping (160x120): at pixel (hcount=13, vcount=9) -> addr_x=3, addr_y=2; at hcount=639 -> addr_x=159; at hcount=700 -> addr_x=0; at vcount=479 -> addr_y=119.
- Alignment: model drives vga_r1 = registered-twice addr_x and G/B = 0x3FF -> VGA_R on the first visible pixel of each line equals 0; no non-zero colour while VGA_BLANK_N=0; PIPE_DELAY=3 variant also passes.
- Mid-frame reset: assert resetn at line 200, pixel 300 for 1 clock -> outputs take reset values immediately (asynchronously); raster restarts at (0,0); next frame_start after exactly 420000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants and logical-resolution helpers.
// Default timing is 640x480@60 on a 25 MHz pixel clock.
package vga_pkg;

   localparam int VGA_H_VIS   = 640;
   localparam int VGA_H_FP    = 16;
   localparam int VGA_H_SYNC  = 96;
   localparam int VGA_H_BP    = 48;
   localparam int VGA_V_VIS   = 480;
   localparam int VGA_V_FP    = 10;
   localparam int VGA_V_SYNC  = 2;
   localparam int VGA_V_BP    = 33;
   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam logic [55:0] VGA_RES_160 = "160x120";
   localparam logic [55:0] VGA_RES_320 = "320x240";

   // Right shift from raster pixel to logical pixel.
   function automatic int res_shift(input logic [55:0] res);
      return (res == VGA_RES_320) ? 1 : 2;
   endfunction

   function automatic int addr_x_w(input logic [55:0] res);
      return $clog2(VGA_H_VIS >> res_shift(res));
   endfunction

   function automatic int addr_y_w(input logic [55:0] res);
      return $clog2(VGA_V_VIS >> res_shift(res));
   endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Pixel-generator address/colour bus plus the VGA DAC pins.
// master = scan generator, slave = pixel generator / DAC board.
interface vga_scan_gen_if
   import vga_pkg::*;
#(
   parameter logic [55:0] RESOLUTION = VGA_RES_160
);

   localparam int AXW = addr_x_w(RESOLUTION);
   localparam int AYW = addr_y_w(RESOLUTION);

   logic [AXW-1:0] addr_x;
   logic [AYW-1:0] addr_y;
   logic           frame_start;
   logic [9:0]     vga_r1;
   logic [9:0]     vga_g1;
   logic [9:0]     vga_b1;
   logic [9:0]     VGA_R;
   logic [9:0]     VGA_G;
   logic [9:0]     VGA_B;
   logic           VGA_HS;
   logic           VGA_VS;
   logic           VGA_BLANK_N;
   logic           VGA_SYNC_N;
   logic           VGA_CLK;

   modport master (
      output addr_x, addr_y, frame_start,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
      input  vga_r1, vga_g1, vga_b1
   );

   modport slave (
      input  addr_x, addr_y, frame_start,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
      output vga_r1, vga_g1, vga_b1
   );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit asynchronous reset value.
// Latency DEPTH clocks; no backpressure.
module vga_delay_line #(
   parameter int               DEPTH   = 2,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge vga_clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster counters, downscaled pixel address, and sync/blank-aligned colour output.
// Address leads colour by PIPE_DELAY; sync/blank/RGB reach the pins PIPE_DELAY+1 after the raster position.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter logic [55:0] RESOLUTION = VGA_RES_160,
   parameter int          H_VIS      = VGA_H_VIS,
   parameter int          H_FP       = VGA_H_FP,
   parameter int          H_SYNC     = VGA_H_SYNC,
   parameter int          H_BP       = VGA_H_BP,
   parameter int          V_VIS      = VGA_V_VIS,
   parameter int          V_FP       = VGA_V_FP,
   parameter int          V_SYNC     = VGA_V_SYNC,
   parameter int          V_BP       = VGA_V_BP,
   parameter int          PIPE_DELAY = 2
) (
   input  logic           vga_clk,
   input  logic           resetn,
   vga_scan_gen_if.master bus
);

   localparam int SHIFT   = res_shift(RESOLUTION);
   localparam int AXW     = addr_x_w(RESOLUTION);
   localparam int AYW     = addr_y_w(RESOLUTION);
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_L = 10'(H_VIS);
   localparam logic [9:0] V_VIS_L = 10'(V_VIS);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

   logic [9:0]     hcount;
   logic [9:0]     vcount;
   logic [9:0]     h_nxt;
   logic [9:0]     v_nxt;
   logic [AXW-1:0] addr_x_q;
   logic [AYW-1:0] addr_y_q;
   logic           frame_start_q;

   always_comb begin
      h_nxt = hcount + 10'd1;
      v_nxt = vcount;
      if (hcount == H_LAST) begin
         h_nxt = '0;
         v_nxt = (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end
   end

   // Address and frame_start are registered from the next raster position
   // so they line up with hcount/vcount rather than trailing them.
   always_ff @(posedge vga_clk or negedge resetn) begin
      if (!resetn) begin
         hcount        <= '0;
         vcount        <= '0;
         addr_x_q      <= '0;
         addr_y_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         hcount        <= h_nxt;
         vcount        <= v_nxt;
         addr_x_q      <= (h_nxt < H_VIS_L) ? AXW'(h_nxt >> SHIFT) : '0;
         addr_y_q      <= (v_nxt < V_VIS_L) ? AYW'(v_nxt >> SHIFT) : '0;
         frame_start_q <= (h_nxt == '0) && (v_nxt == '0);
      end
   end

   logic       hs_raw;
   logic       vs_raw;
   logic       blank_raw;
   logic [2:0] dly_out;

   assign hs_raw    = !((hcount >= HS_BEG) && (hcount < HS_END));
   assign vs_raw    = !((vcount >= VS_BEG) && (vcount < VS_END));
   assign blank_raw = (hcount < H_VIS_L) && (vcount < V_VIS_L);

   vga_delay_line #(
      .DEPTH   (PIPE_DELAY),
      .WIDTH   (3),
      .RST_VAL (3'b110)
   ) u_sync_dly (
      .vga_clk (vga_clk),
      .resetn  (resetn),
      .din     ({hs_raw, vs_raw, blank_raw}),
      .dout    (dly_out)
   );

   logic       hs_q;
   logic       vs_q;
   logic       blank_q;
   logic [9:0] r_q;
   logic [9:0] g_q;
   logic [9:0] b_q;

   // Final stage doubles as the RGB capture register so sync, blank and
   // colour all change on the same edge.
   always_ff @(posedge vga_clk or negedge resetn) begin
      if (!resetn) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         hs_q    <= dly_out[2];
         vs_q    <= dly_out[1];
         blank_q <= dly_out[0];
         r_q     <= dly_out[0] ? bus.vga_r1 : '0;
         g_q     <= dly_out[0] ? bus.vga_g1 : '0;
         b_q     <= dly_out[0] ? bus.vga_b1 : '0;
      end
   end

   assign bus.addr_x      = addr_x_q;
   assign bus.addr_y      = addr_y_q;
   assign bus.frame_start = frame_start_q;
   assign bus.VGA_HS      = hs_q;
   assign bus.VGA_VS      = vs_q;
   assign bus.VGA_BLANK_N = blank_q;
   assign bus.VGA_R       = r_q;
   assign bus.VGA_G       = g_q;
   assign bus.VGA_B       = b_q;
   assign bus.VGA_SYNC_N  = 1'b0;
   assign bus.VGA_CLK     = vga_clk;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Two configurations (full 640x480 timing / PIPE_DELAY=2 and a shrunk raster / PIPE_DELAY=3)
// checked every cycle against a raster model computed from the cycle count since reset.
module tb_vga_scan_gen;
   import vga_pkg::*;

   localparam int PA  = 2;
   localparam int PB  = 3;
   localparam int BHV = 64, BHF = 4, BHS = 8, BHB = 4;
   localparam int BVV = 48, BVF = 2, BVS = 2, BVB = 3;
   localparam int BTOT = (BHV + BHF + BHS + BHB) * (BVV + BVF + BVS + BVB);
   localparam int CYCLES = 15200;

   typedef struct {
      int ax; int ay; int fs; int hs; int vs; int bl; int rx;
   } exp_t;

   logic vga_clk = 1'b0;
   logic rstn_a  = 1'b0;
   logic rstn_b  = 1'b0;

   always #20 vga_clk = ~vga_clk;

   vga_scan_gen_if #(.RESOLUTION(VGA_RES_160)) bus_a ();
   vga_scan_gen_if #(.RESOLUTION(VGA_RES_320)) bus_b ();

   vga_scan_gen #(
      .RESOLUTION(VGA_RES_160), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .PIPE_DELAY(PA)
   ) dut_a (
      .vga_clk (vga_clk),
      .resetn  (rstn_a),
      .bus     (bus_a)
   );

   vga_scan_gen #(
      .RESOLUTION(VGA_RES_320), .H_VIS(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
      .V_VIS(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .PIPE_DELAY(PB)
   ) dut_b (
      .vga_clk (vga_clk),
      .resetn  (rstn_b),
      .bus     (bus_b)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int na = 0, nb = 0;
   int ga_prev = 0, gb_prev = 0;
   int hist_a [PA+1];
   int hist_b [PB+1];
   int gap_b = 0, fs_b_seen = 0;
   bit a_reset_done = 0, b_reset_done = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // n = rising edges since reset release; the pins show the raster position n-(p+1).
   function automatic exp_t model(input int n, input int hv, input int hfp, input int hsy, input int hbp,
                                  input int vv, input int vfp, input int vsy, input int vbp,
                                  input int p, input int sh);
      exp_t e;
      int ht, vt, pos, h, v, m;
      ht  = hv + hfp + hsy + hbp;
      vt  = vv + vfp + vsy + vbp;
      pos = n % (ht * vt);
      h   = pos % ht;
      v   = pos / ht;
      e.fs = (n > 0 && pos == 0) ? 1 : 0;
      e.ax = (h < hv) ? (h >> sh) : 0;
      e.ay = (v < vv) ? (v >> sh) : 0;
      m = n - p - 1;
      if (m < 0) begin
         e.hs = 1; e.vs = 1; e.bl = 0; e.rx = 0;
      end else begin
         pos  = m % (ht * vt);
         h    = pos % ht;
         v    = pos / ht;
         e.hs = (h >= hv + hfp && h < hv + hfp + hsy) ? 0 : 1;
         e.vs = (v >= vv + vfp && v < vv + vfp + vsy) ? 0 : 1;
         e.bl = (h < hv && v < vv) ? 1 : 0;
         e.rx = (h < hv) ? (h >> sh) : 0;
      end
      return e;
   endfunction

   task automatic check_dut(input string t, input exp_t e, input int gprev,
                            input int ax, input int ay, input int fs, input int hs, input int vs,
                            input int bl, input int r, input int g, input int b, input int sn, input int ck);
      check({t, "_addr_x"}, ax, e.ax);
      check({t, "_addr_y"}, ay, e.ay);
      check({t, "_frame_start"}, fs, e.fs);
      check({t, "_hs"}, hs, e.hs);
      check({t, "_vs"}, vs, e.vs);
      check({t, "_blank_n"}, bl, e.bl);
      check({t, "_r"}, r, e.bl ? e.rx : 0);
      check({t, "_g"}, g, e.bl ? gprev : 0);
      check({t, "_b"}, b, e.bl ? 1023 : 0);
      check({t, "_sync_n"}, sn, 0);
      check({t, "_vga_clk"}, ck, 0);
   endtask

   task automatic check_reset_vals(input string t, input int ax, input int ay, input int fs,
                                   input int hs, input int vs, input int bl, input int r);
      check({t, "_rst_addr_x"}, ax, 0);
      check({t, "_rst_addr_y"}, ay, 0);
      check({t, "_rst_fs"}, fs, 0);
      check({t, "_rst_hs"}, hs, 1);
      check({t, "_rst_vs"}, vs, 1);
      check({t, "_rst_blank_n"}, bl, 0);
      check({t, "_rst_r"}, r, 0);
   endtask

   task automatic step();
      @(posedge vga_clk);
      if (rstn_a) na++;
      if (rstn_b) begin nb++; gap_b++; end
      #1;
      ga_prev = int'(bus_a.vga_g1);
      gb_prev = int'(bus_b.vga_g1);
      for (int i = PA; i > 0; i--) hist_a[i] = hist_a[i-1];
      hist_a[0] = int'(bus_a.addr_x);
      for (int i = PB; i > 0; i--) hist_b[i] = hist_b[i-1];
      hist_b[0] = int'(bus_b.addr_x);
      bus_a.vga_r1 = 10'(hist_a[PA]);
      bus_a.vga_g1 = 10'($urandom);
      bus_a.vga_b1 = 10'h3FF;
      bus_b.vga_r1 = 10'(hist_b[PB]);
      bus_b.vga_g1 = 10'($urandom);
      bus_b.vga_b1 = 10'h3FF;
      @(negedge vga_clk);
      check_dut("a", model(na, 640, 16, 96, 48, 480, 10, 2, 33, PA, 2), ga_prev,
                int'(bus_a.addr_x), int'(bus_a.addr_y), int'(bus_a.frame_start), int'(bus_a.VGA_HS),
                int'(bus_a.VGA_VS), int'(bus_a.VGA_BLANK_N), int'(bus_a.VGA_R), int'(bus_a.VGA_G),
                int'(bus_a.VGA_B), int'(bus_a.VGA_SYNC_N), int'(bus_a.VGA_CLK));
      check_dut("b", model(nb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, PB, 1), gb_prev,
                int'(bus_b.addr_x), int'(bus_b.addr_y), int'(bus_b.frame_start), int'(bus_b.VGA_HS),
                int'(bus_b.VGA_VS), int'(bus_b.VGA_BLANK_N), int'(bus_b.VGA_R), int'(bus_b.VGA_G),
                int'(bus_b.VGA_B), int'(bus_b.VGA_SYNC_N), int'(bus_b.VGA_CLK));
      if (bus_b.frame_start) begin
         check("b_fs_period", gap_b, BTOT);
         fs_b_seen++;
         gap_b = 0;
      end
   endtask

   initial begin
      for (int i = 0; i <= PA; i++) hist_a[i] = 0;
      for (int i = 0; i <= PB; i++) hist_b[i] = 0;
      bus_a.vga_r1 = '0; bus_a.vga_g1 = '0; bus_a.vga_b1 = '0;
      bus_b.vga_r1 = '0; bus_b.vga_g1 = '0; bus_b.vga_b1 = '0;

      repeat (10) step();
      rstn_a = 1'b1;
      rstn_b = 1'b1;

      for (int c = 0; c < CYCLES; c++) begin
         step();
         if (!a_reset_done) begin
            if (na == 9*800 + 13) begin
               check("a_addr_x_at_13", int'(bus_a.addr_x), 3);
               check("a_addr_y_at_9", int'(bus_a.addr_y), 2);
            end
            if (na == 639) check("a_addr_x_at_639", int'(bus_a.addr_x), 159);
            if (na == 640) check("a_addr_x_at_640", int'(bus_a.addr_x), 0);
            if (na == 700) check("a_addr_x_at_700", int'(bus_a.addr_x), 0);
            if (na == 656 + PA) check("a_hs_before_low", int'(bus_a.VGA_HS), 1);
            if (na == 656 + PA + 1) check("a_hs_first_low", int'(bus_a.VGA_HS), 0);
            if (na == 751 + PA + 1) check("a_hs_last_low", int'(bus_a.VGA_HS), 0);
            if (na == 752 + PA + 1) check("a_hs_after_low", int'(bus_a.VGA_HS), 1);
            if (na == 12*800 + 300) begin
               rstn_a = 1'b0;
               #1;
               check_reset_vals("a_mid", int'(bus_a.addr_x), int'(bus_a.addr_y), int'(bus_a.frame_start),
                                int'(bus_a.VGA_HS), int'(bus_a.VGA_VS), int'(bus_a.VGA_BLANK_N),
                                int'(bus_a.VGA_R));
               na = 0;
               step();
               rstn_a = 1'b1;
               a_reset_done = 1;
            end
         end
         if (!b_reset_done && nb == 2*BTOT + 20*(BHV + BHF + BHS + BHB) + 30) begin
            rstn_b = 1'b0;
            #1;
            check_reset_vals("b_mid", int'(bus_b.addr_x), int'(bus_b.addr_y), int'(bus_b.frame_start),
                             int'(bus_b.VGA_HS), int'(bus_b.VGA_VS), int'(bus_b.VGA_BLANK_N),
                             int'(bus_b.VGA_R));
            nb = 0;
            gap_b = 0;
            step();
            rstn_b = 1'b1;
            b_reset_done = 1;
         end
      end

      check("b_frame_start_count", fs_b_seen, 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
